// File: rtl/dota_pkg.sv
// dota_pkg: shared FSM state type and default parameters for the OTA measurement sequencer
package dota_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, REPORT} dota_meas_state_t;
    localparam int DEF_CH = 4;
    localparam int DEF_DUTY_W = 4;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_SETTLE_CYC = 8;
endpackage

// File: rtl/dota_pwm_gen.sv
// dota_pwm_gen: free-running PWM counter with INP/INN duty comparators
module dota_pwm_gen #(
    parameter int DUTY_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [DUTY_W-1:0] duty_p,
    input  logic [DUTY_W-1:0] duty_n,
    output logic              p_hi,
    output logic              n_hi
);
    logic [DUTY_W-1:0] pwm_cnt;
    always_ff @(posedge clk) pwm_cnt <= (rst || clr) ? '0 : pwm_cnt + DUTY_W'(1);
    always_comb begin
        p_hi = pwm_cnt < duty_p;
        n_hi = pwm_cnt < duty_n;
    end
endmodule

// File: rtl/dota_meas_seq.sv
// dota_meas_seq: sweeps PWM stimulus across CH OTA channels and counts synchronised high samples per channel
module dota_meas_seq
    import dota_pkg::*;
#(
    parameter int CH         = DEF_CH,
    parameter int DUTY_W     = DEF_DUTY_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DUTY_W-1:0]     duty_p,
    input  logic [DUTY_W-1:0]     duty_n,
    input  logic [CNT_W-1:0]      win_len,
    input  logic [CH-1:0]         ota_out,
    output logic [CH-1:0]         stim_p,
    output logic [CH-1:0]         stim_n,
    output logic                  busy,
    output logic [$clog2(CH)-1:0] ch_idx,
    output logic                  res_valid,
    output logic [CNT_W-1:0]      res_data,
    output logic                  done
);
    localparam int IW = $clog2(CH);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [IW-1:0] LAST_CH = IW'(CH - 1);
    dota_meas_state_t  state;
    logic [DUTY_W-1:0] duty_p_q, duty_n_q;
    logic [CNT_W-1:0]  win_q, ph, cnt, cnt_inc;
    logic [CH-1:0]     sync1, sync2, sel;
    logic              p_hi, n_hi, pwm_clr, settle_end, meas_end, to_report, run_nxt, last_ch;

    dota_pwm_gen #(.DUTY_W(DUTY_W)) u_pwm (
        .clk(clk),
        .rst(rst),
        .clr(pwm_clr),
        .duty_p(duty_p_q),
        .duty_n(duty_n_q),
        .p_hi(p_hi),
        .n_hi(n_hi)
    );

    always_ff @(posedge clk) {sync2, sync1} <= rst ? '0 : {sync1, ota_out};

    // run_nxt keeps the stimulus low in IDLE and REPORT while staying registered
    always_comb begin
        sel        = CH'(1) << ch_idx;
        last_ch    = ch_idx == LAST_CH;
        pwm_clr    = state == IDLE || state == REPORT;
        settle_end = state == SETTLE && ph == SET_LAST;
        meas_end   = state == MEASURE && ph == win_q - CNT_W'(1);
        to_report  = (settle_end && win_q == '0) || meas_end;
        run_nxt    = (state == SETTLE || state == MEASURE) && !to_report;
        cnt_inc    = cnt + CNT_W'(state == MEASURE && sync2[ch_idx]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            duty_p_q  <= '0;
            duty_n_q  <= '0;
            win_q     <= '0;
            ph        <= '0;
            cnt       <= '0;
            ch_idx    <= '0;
            busy      <= 1'b0;
            stim_p    <= '0;
            stim_n    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            done      <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            done      <= 1'b0;
            stim_p    <= run_nxt ? sel & {CH{p_hi}} : '0;
            stim_n    <= run_nxt ? sel & {CH{n_hi}} : '0;
            case (state)
                IDLE: if (start) begin
                    duty_p_q <= duty_p;
                    duty_n_q <= duty_n;
                    win_q    <= win_len;
                    ch_idx   <= '0;
                    cnt      <= '0;
                    ph       <= '0;
                    busy     <= 1'b1;
                    state    <= SETTLE;
                end
                SETTLE: begin
                    ph <= settle_end ? '0 : ph + CNT_W'(1);
                    if (settle_end) state <= (win_q == '0) ? REPORT : MEASURE;
                end
                MEASURE: begin
                    cnt <= cnt_inc;
                    ph  <= ph + CNT_W'(1);
                    if (meas_end) state <= REPORT;
                end
                REPORT: begin
                    cnt <= '0;
                    ph  <= '0;
                    if (last_ch) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        ch_idx <= ch_idx + IW'(1);
                        state  <= SETTLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (to_report) begin
                res_valid <= 1'b1;
                res_data  <= cnt_inc;
                done      <= last_ch;
            end
        end
    end
endmodule

// File: tb/tb_dota_meas_seq.sv
// tb_dota_meas_seq: directed and randomized sweeps checked against an arithmetic model of the sequencer
module tb_dota_meas_seq;
    localparam int CH = 4, DUTY_W = 4, CNT_W = 16, SETTLE = 8, PER = 16;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, loop_en = 1'b0;
    logic [DUTY_W-1:0] duty_p = '0, duty_n = '0;
    logic [CNT_W-1:0] win_len = '0, res_data;
    logic [CH-1:0] ota_out, ota_const = '0, stim_p, stim_n;
    logic busy, res_valid, done;
    logic [$clog2(CH)-1:0] ch_idx;
    int errors = 0, checks = 0;

    assign ota_out = loop_en ? stim_p : ota_const;
    always #5 clk = ~clk;

    dota_meas_seq #(.CH(CH), .DUTY_W(DUTY_W), .CNT_W(CNT_W), .SETTLE_CYC(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start), .duty_p(duty_p), .duty_n(duty_n),
        .win_len(win_len), .ota_out(ota_out), .stim_p(stim_p), .stim_n(stim_n),
        .busy(busy), .ch_idx(ch_idx), .res_valid(res_valid), .res_data(res_data), .done(done)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // window sample i sees the PWM phase 3 cycles older than the counter (2 sync flops + count)
    function automatic int model_cnt(input int d, input int w);
        int c = 0;
        for (int i = 0; i < w; i++) if ((SETTLE - 3 + i) % PER < d) c++;
        return c;
    endfunction

    // stimulus is driven from the 2nd settle cycle through the last measure cycle of each channel
    function automatic int model_stim(input int d, input int w);
        int c = 0;
        for (int j = 0; j < SETTLE + w - 1; j++) if (j % PER < d) c++;
        return CH * c;
    endfunction

    task automatic sweep(input string tag, input int dp, input int dn, input int w, input int poke);
        int per, n, done_at, p_hi, n_hi, stray;
        int got[CH], at[CH], gch[CH];
        per = SETTLE + w + 1;
        n = 0; done_at = -1; p_hi = 0; n_hi = 0; stray = 0;
        duty_p = DUTY_W'(dp); duty_n = DUTY_W'(dn); win_len = CNT_W'(w); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= CH * per + 20 && done_at < 0; k++) begin
            p_hi += $countones(stim_p);
            n_hi += $countones(stim_n);
            if (((stim_p | stim_n) & ~(CH'(1) << ch_idx)) != 0 || ((!busy || res_valid) && (stim_p | stim_n) != 0)) stray++;
            if (res_valid) begin
                if (n < CH) begin got[n] = int'(res_data); at[n] = k; gch[n] = int'(ch_idx); end
                n++;
            end
            if (done) done_at = k;
            start = (k == poke);
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "/pulses"}, n, CH);
        chk({tag, "/done_at"}, done_at, CH * per);
        chk({tag, "/busy_fall"}, busy, 0);
        chk({tag, "/stray_stim"}, stray, 0);
        chk({tag, "/stim_p_hi"}, p_hi, model_stim(dp, w));
        chk({tag, "/stim_n_hi"}, n_hi, model_stim(dn, w));
        for (int i = 0; i < CH; i++) begin
            chk({tag, "/ch"}, gch[i], i);
            chk({tag, "/at"}, at[i], (i + 1) * per);
            chk({tag, "/res"}, got[i], loop_en ? model_cnt(dp, w) : (ota_const[i] ? w : 0));
        end
    endtask

    initial begin
        int nv, nd;
        rst = 1'b1; start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_outs", {busy, done, res_valid, stim_p, stim_n, res_data, ch_idx}, 0);
        end
        rst = 1'b0; start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("rst_no_sweep", busy, 0);
        end
        loop_en = 1'b1;
        sweep("loop8", 8, 4, 64, -1);
        loop_en = 1'b0; ota_const = 4'b1111;
        sweep("const1", 3, 9, 100, -1);
        ota_const = 4'b0000;
        sweep("const0", 3, 9, 100, -1);
        loop_en = 1'b1;
        sweep("zero_win", 8, 8, 0, -1);
        sweep("duty0", 0, 11, 64, -1);
        sweep("duty15", 15, 1, 64, -1);
        sweep("poke", 5, 7, 40, 20);
        sweep("back2back", 5, 7, 40, -1);
        for (int r = 0; r < 4; r++) begin
            loop_en = 1'($urandom_range(0, 1));
            ota_const = CH'($urandom);
            sweep("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 50)), -1);
        end
        loop_en = 1'b1;
        duty_p = 4'd6; duty_n = 4'd2; win_len = 16'd30; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * (SETTLE + 30 + 1) + SETTLE + 4) @(negedge clk);
        chk("abort_ch", ch_idx, 2);
        chk("abort_busy_pre", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outs", {busy, done, res_valid, stim_p, stim_n, res_data, ch_idx}, 0);
        nv = 0; nd = 0;
        repeat (200) begin
            @(negedge clk);
            nv += int'(res_valid);
            nd += int'(done);
        end
        chk("abort_valid", nv, 0);
        chk("abort_done", nd, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dota_meas_seq.md
# dota_meas_seq

Parametrised on-chip measurement sequencer for an array of NOR-based digital OTA instances. It drives PWM stimulus onto the differential inputs of one OTA channel at a time. It then synchronises that channel's raw output and counts high samples over a programmable window, stepping through all channels and reporting one duty-cycle count per channel. It is the successor to the single-instance digital OTA tile: it generalises to CH channels with programmable stimulus and built-in result capture.

## Interface
Parameters:
- CH, 4, number of OTA channels, ≥2
- DUTY_W, 4, PWM counter width; PWM period = 2^DUTY_W cycles
- CNT_W, 16, window-length and result width
- SETTLE_CYC, 8, stimulus cycles discarded before each measurement window, ≥3

Ports:
- clk  in  1  single clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a sweep
- duty_p  in  DUTY_W  high-time per period for the INP stimulus
- duty_n  in  DUTY_W  high-time per period for the INN stimulus
- win_len  in  CNT_W  samples counted per channel
- ota_out  in  CH  raw, asynchronous OTA outputs
- stim_p  out  CH  INP stimulus; only the selected channel toggles
- stim_n  out  CH  INN stimulus; only the selected channel toggles
- busy  out  1  sweep in progress
- ch_idx  out  clog2(CH)  channel currently selected or being reported
- res_valid  out  1  one-cycle pulse; res_data is valid
- res_data  out  CNT_W  high-sample count for ch_idx
- done  out  1  one-cycle pulse at sweep end

## Operation
- FSM states: IDLE, SETTLE, MEASURE, REPORT.
- IDLE:
  - On start=1: latch duty_p, duty_n and win_len. Set ch_idx=0, clear the PWM counter and the result counter, and go to SETTLE.
  - start is ignored in all other states.
- SETTLE: PWM runs for exactly SETTLE_CYC cycles, then go to MEASURE. If the latched win_len==0, go directly to REPORT instead.
- MEASURE: runs for exactly win_len cycles. Each cycle the result counter increments when the synchronised ota_out[ch_idx]==1. Then go to REPORT.
- REPORT: one cycle.
  - res_valid=1, res_data=count, ch_idx unchanged.
  - If ch_idx==CH-1: go to IDLE and pulse done.
  - Otherwise: increment ch_idx, clear the PWM and result counters, and go to SETTLE.
- PWM:
  - pwm_cnt is a free-running DUTY_W-bit counter, cleared on entering SETTLE.
  - stim_p[ch_idx] = (pwm_cnt < duty_p); stim_n[ch_idx] = (pwm_cnt < duty_n). Both are registered.
  - duty=0 gives a constant 0; there is no constant-1 setting (maximum duty is (2^DUTY_W−1)/2^DUTY_W).
  - Unselected channels are held at 0. All stim bits are 0 in IDLE and REPORT.
- Synchroniser:
  - Two flops on every ota_out bit, cleared by rst.
  - The SETTLE_CYC≥3 minimum covers the pipeline fill.
- Arithmetic: count ≤ win_len ≤ 2^CNT_W−1, so no overflow or saturation logic is needed.

## Timing
- Reset: all outputs are 0 on the cycle after rst=1. FSM goes to IDLE; all counters and synchroniser flops are cleared.
- Reset mid-sweep aborts the sweep: no res_valid and no done are issued. rst has priority over start in the same cycle.
- start is sampled at edge N. busy=1 and SETTLE begin at edge N+1.
- Per channel: SETTLE_CYC + win_len + 1 cycles (SETTLE_CYC + 1 when win_len==0).
- done: asserted in the same cycle as the last res_valid. busy falls at the next edge.
- A start arriving in the cycle after done begins a new sweep normally.
- Total latency from start to done: CH·(SETTLE_CYC + win_len + 1) cycles.
- ota_out-to-count latency: 3 cycles (2 synchroniser flops + counter).

## Structure
- Shared package dota_pkg holds:
  - the FSM state enum type dota_meas_state_t
  - the default parameter constants
- One natural sub-module: dota_pwm_gen. It contains the counter and comparators and is instantiated once. Its outputs are steered to the selected channel by the sequencer.
- The synchroniser is inlined as a CH-wide two-flop vector.

## Test plan
Parameters for all scenarios: CH=4, DUTY_W=4, CNT_W=16, SETTLE_CYC=8.
- Reset: hold rst 3 cycles with start=1 → busy, done, res_valid, stim_p and stim_n all 0, and no sweep starts.
- Loopback: ota_out=stim_p, duty_p=8, win_len=64 → four res_valid pulses, ch_idx 0..3, res_data=32 each. done coincides with the 4th pulse, 292 cycles after start.
- Constants: ota_out=4'b1111, win_len=100 → res_data=100 ×4. Then ota_out=0 → res_data=0 ×4.
- Zero window: win_len=0 → four res_valid pulses with res_data=0, spaced 9 cycles apart. done at cycle 36.
- Duty extremes:
  - duty_p=0 → stim_p stays 0 for the whole sweep.
  - duty_p=15 with loopback and win_len=64 → res_data=60.
  - stim_n tracks duty_n independently.
- Abuse:
  - start pulsed during MEASURE → ignored, results unchanged.
  - rst during channel 2 MEASURE → busy=0 next cycle; no further res_valid and no done pulse.
